// File: rtl/div_arbiter_pkg.sv
// Shared types and defaults for the divider arbiter and the blocks that reuse the divider.
package div_arbiter_pkg;

  localparam int unsigned DEF_N_REQ   = 3;
  localparam int unsigned DEF_WIDTH   = 16;
  localparam int unsigned DEF_TIMEOUT = 64;
  localparam int unsigned DEF_TO_W    = 7;

  localparam logic [DEF_WIDTH-1:0] SAT_VALUE = '1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_BUSY  = 3'd2,
    ST_WAIT_READY = 3'd3,
    ST_RESP       = 3'd4
  } arb_state_e;

  // Index width for N entries, never less than one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_arbiter_rr_picker.sv
// Combinational round-robin select: first pending bit at or above rr_ptr, with wrap.
module div_arbiter_rr_picker
  import div_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned PTR_W = ptr_width(N_REQ)
) (
  input  logic [N_REQ-1:0] pending_i,
  input  logic [PTR_W-1:0] rr_ptr_i,
  output logic [N_REQ-1:0] sel_oh_c_o,
  output logic [PTR_W-1:0] sel_idx_c_o,
  output logic             sel_vld_c_o
);

  always_comb begin
    int unsigned cand;
    sel_oh_c_o  = '0;
    sel_idx_c_o = '0;
    sel_vld_c_o = 1'b0;
    cand        = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 32'(rr_ptr_i) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (!sel_vld_c_o && pending_i[PTR_W'(cand)]) begin
        sel_oh_c_o[PTR_W'(cand)] = 1'b1;
        sel_idx_c_o              = PTR_W'(cand);
        sel_vld_c_o              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one sequential divider among N_REQ requesters: round-robin grant,
// start/busy/ready sequencing, local divide-by-zero and a hang watchdog.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ   = DEF_N_REQ,
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned TO_W    = DEF_TO_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] dividend_bus,
  input  logic [N_REQ*WIDTH-1:0] divisor_bus,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       result,
  output logic                   err,
  output logic [N_REQ-1:0]       gnt,
  output logic                   div_start,
  output logic [WIDTH-1:0]       div_dividend,
  output logic [WIDTH-1:0]       div_divisor,
  input  logic                   div_busy,
  input  logic                   div_ready,
  input  logic [WIDTH-1:0]       div_quotient
);

  localparam int unsigned      PTR_W    = ptr_width(N_REQ);
  localparam logic [WIDTH-1:0] SAT      = {WIDTH{1'b1}};
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0] idx_q, idx_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             start_q, start_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [TO_W-1:0]  wdog_q, wdog_d;

  logic [N_REQ-1:0] sel_oh_c;
  logic [PTR_W-1:0] sel_idx_c;
  logic             sel_vld_c;
  logic [N_REQ-1:0] grant_clr_c;
  logic [WIDTH-1:0] op_a_c;
  logic [WIDTH-1:0] op_b_c;

  div_arbiter_rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .pending_i   (pending_q),
    .rr_ptr_i    (rr_ptr_q),
    .sel_oh_c_o  (sel_oh_c),
    .sel_idx_c_o (sel_idx_c),
    .sel_vld_c_o (sel_vld_c)
  );

  // Operand slice of the requester the picker selected.
  always_comb begin
    op_a_c = '0;
    op_b_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (sel_oh_c[i]) begin
        op_a_c = dividend_bus[i*WIDTH +: WIDTH];
        op_b_c = divisor_bus[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and registered-output logic. div_start is looked ahead from
  // IDLE so an uncontended start lands in the first ISSUE cycle.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    idx_d       = idx_q;
    rr_ptr_d    = rr_ptr_q;
    done_d      = '0;
    err_d       = err_q;
    result_d    = result_q;
    start_d     = 1'b0;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    wdog_d      = wdog_q;
    grant_clr_c = '0;

    case (state_q)
      ST_IDLE: begin
        if (sel_vld_c) begin
          gnt_d       = sel_oh_c;
          idx_d       = sel_idx_c;
          dvd_d       = op_a_c;
          dvs_d       = op_b_c;
          grant_clr_c = sel_oh_c;
          if (op_b_c == '0) begin
            state_d  = ST_RESP;
            done_d   = sel_oh_c;
            result_d = SAT;
            err_d    = 1'b1;
          end else begin
            state_d = ST_ISSUE;
            start_d = !div_busy;
          end
        end
      end

      ST_ISSUE: begin
        if (start_q) begin
          state_d = ST_WAIT_BUSY;
          wdog_d  = '0;
        end else if (!div_busy) begin
          start_d = 1'b1;
        end
      end

      ST_WAIT_BUSY: begin
        wdog_d = wdog_q + TO_W'(1);
        if (wdog_q == TO_LAST) begin
          state_d  = ST_RESP;
          done_d   = gnt_q;
          result_d = SAT;
          err_d    = 1'b1;
        end else if (div_busy) begin
          state_d = ST_WAIT_READY;
        end
      end

      ST_WAIT_READY: begin
        wdog_d = wdog_q + TO_W'(1);
        if (div_ready) begin
          state_d  = ST_RESP;
          done_d   = gnt_q;
          result_d = div_quotient;
          err_d    = 1'b0;
        end else if (wdog_q == TO_LAST) begin
          state_d  = ST_RESP;
          done_d   = gnt_q;
          result_d = SAT;
          err_d    = 1'b1;
        end
      end

      ST_RESP: begin
        state_d  = ST_IDLE;
        gnt_d    = '0;
        rr_ptr_d = (idx_q == PTR_LAST) ? '0 : idx_q + PTR_W'(1);
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Duplicate requests from an already pending or granted requester are dropped.
  assign pending_d = (pending_q & ~grant_clr_c) | (req & ~pending_q & ~gnt_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      gnt_q     <= '0;
      idx_q     <= '0;
      rr_ptr_q  <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      result_q  <= '0;
      start_q   <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      rr_ptr_q  <= rr_ptr_d;
      done_q    <= done_d;
      err_q     <= err_d;
      result_q  <= result_d;
      start_q   <= start_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      wdog_q    <= wdog_d;
    end
  end

  assign done         = done_q;
  assign result       = result_q;
  assign err          = err_q;
  assign gnt          = gnt_q;
  assign div_start    = start_q;
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a small behavioural divider on the far side.
module tb_div_arbiter;
  import div_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req = '0;
  logic [47:0] dividend_bus = '0;
  logic [47:0] divisor_bus = '0;
  logic [2:0]  done;
  logic [15:0] result;
  logic        err;
  logic [2:0]  gnt;
  logic        div_start;
  logic [15:0] div_dividend;
  logic [15:0] div_divisor;
  logic        div_busy;
  logic        div_ready;
  logic [15:0] div_quotient;

  logic        model_busy = 1'b0;
  logic        model_ready = 1'b0;
  logic [15:0] model_q = '0;
  logic        force_busy = 1'b0;
  logic        force_ready = 1'b0;
  int unsigned m_delay = 8;
  logic        m_hang = 1'b0;
  int unsigned m_cnt = 0;
  logic [15:0] m_res = '0;

  int unsigned cyc = 0;
  int unsigned n_starts = 0;
  int unsigned last_start_cyc = 0;
  int unsigned multi_done = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  assign div_busy     = model_busy | force_busy;
  assign div_ready    = model_ready | force_ready;
  assign div_quotient = force_ready ? 16'hDEAD : model_q;

  div_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .dividend_bus (dividend_bus),
    .divisor_bus  (divisor_bus),
    .done         (done),
    .result       (result),
    .err          (err),
    .gnt          (gnt),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_busy     (div_busy),
    .div_ready    (div_ready),
    .div_quotient (div_quotient)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: busy from one cycle after start for 8 cycles, ready m_delay cycles after busy.
  always @(negedge clk) begin
    if (!rst) begin
      m_cnt       = 0;
      model_busy  = 1'b0;
      model_ready = 1'b0;
    end else begin
      model_ready = 1'b0;
      if (div_start) begin
        n_starts++;
        last_start_cyc = cyc;
        m_cnt = 1;
        m_res = (div_divisor != 0) ? div_dividend / div_divisor : 16'hFFFF;
      end else if (m_cnt != 0) begin
        m_cnt++;
        if (m_cnt == 2) model_busy = 1'b1;
        if (m_cnt == 10) model_busy = 1'b0;
        if (m_cnt == 2 + m_delay && !m_hang) begin
          model_ready = 1'b1;
          model_q     = m_res;
        end
        if (m_cnt > 2 + m_delay && m_cnt > 10) m_cnt = 0;
      end
    end
    if ($countones(done) > 1) multi_done++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1);
  end

  typedef struct {
    int unsigned rq;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  exp_done;
    logic [15:0] exp_res;
    logic        exp_err;
    int unsigned exp_lat;
    int unsigned exp_starts;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_ops(input int unsigned rq, input logic [15:0] a, input logic [15:0] b);
    dividend_bus[rq*16 +: 16] = a;
    divisor_bus[rq*16 +: 16]  = b;
  endtask

  // Drives a one-cycle request; c0 is the cycle the pulse is high, returns in cycle c0+1.
  task automatic run_req(input logic [2:0] mask, output int unsigned c0);
    req = mask;
    c0  = cyc;
    tick();
    req = '0;
  endtask

  task automatic wait_done(input string name, input int unsigned budget, output int unsigned at);
    int unsigned n;
    n = 0;
    while (done == 3'b000 && n < budget) begin
      tick();
      n++;
    end
    at = cyc;
    check({name, " done_seen"}, 32'(done != 3'b000), 32'd1);
  endtask

  function automatic int unsigned oh2idx(input logic [2:0] oh);
    int unsigned r;
    r = 99;
    for (int unsigned k = 0; k < 3; k++) if (oh[k]) r = k;
    return r;
  endfunction

  // One request through to completion with full response checks.
  task automatic one_shot(input string name, input int unsigned rq, input logic [15:0] exp_res,
                          input logic exp_err, input int unsigned exp_lat);
    int unsigned c0, at;
    run_req(3'(1 << rq), c0);
    wait_done(name, 200, at);
    check({name, " done"}, 32'(done), 32'(1 << rq));
    check({name, " result"}, 32'(result), 32'(exp_res));
    check({name, " err"}, 32'(err), 32'(exp_err));
    check({name, " latency"}, at - c0, exp_lat);
    tick();
  endtask

  initial begin
    int unsigned c0, at, s0, nd, t2;
    logic        rereq;
    logic        bad;
    int unsigned ord[4];
    logic [15:0] res[4];
    logic [3:0]  errs;

    vecs[0] = '{0, 16'd1200,  16'd25,   3'b001, 16'd48,    1'b0, 12, 1};
    vecs[1] = '{1, 16'd1234,  16'd0,    3'b010, 16'hFFFF,  1'b1, 2,  0};
    vecs[2] = '{2, 16'd65535, 16'd1,    3'b100, 16'd65535, 1'b0, 12, 1};
    vecs[3] = '{1, 16'd1000,  16'd1000, 3'b010, 16'd1,     1'b0, 12, 1};
    vecs[4] = '{0, 16'd7,     16'd9,    3'b001, 16'd0,     1'b0, 12, 1};
    vecs[5] = '{2, 16'd0,     16'd0,    3'b100, 16'hFFFF,  1'b1, 2,  0};

    // Reset state
    tick();
    tick();
    check("rst gnt", 32'(gnt), 0);
    check("rst done", 32'(done), 0);
    check("rst err", 32'(err), 0);
    check("rst result", 32'(result), 0);
    check("rst div_start", 32'(div_start), 0);
    check("rst div_dividend", 32'(div_dividend), 0);
    check("rst div_divisor", 32'(div_divisor), 0);
    rst = 1'b1;
    tick();

    // Table of single uncontended requests
    for (int i = 0; i < 6; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      set_ops(vecs[i].rq, vecs[i].a, vecs[i].b);
      s0 = n_starts;
      run_req(3'(1 << vecs[i].rq), c0);
      wait_done(nm, 200, at);
      check({nm, " done"}, 32'(done), 32'(vecs[i].exp_done));
      check({nm, " gnt"}, 32'(gnt), 32'(vecs[i].exp_done));
      check({nm, " result"}, 32'(result), 32'(vecs[i].exp_res));
      check({nm, " err"}, 32'(err), 32'(vecs[i].exp_err));
      check({nm, " latency"}, at - c0, vecs[i].exp_lat);
      check({nm, " starts"}, n_starts - s0, vecs[i].exp_starts);
      if (vecs[i].exp_starts != 0) check({nm, " start_cycle"}, last_start_cyc - c0, 2);
      tick();
      check({nm, " done_cleared"}, 32'(done), 0);
      check({nm, " gnt_cleared"}, 32'(gnt), 0);
    end

    // Contention: all three at once from rr_ptr 0, then a repeat from requester 0
    set_ops(0, 16'd100, 16'd10);
    set_ops(1, 16'd90, 16'd3);
    set_ops(2, 16'd81, 16'd9);
    multi_done = 0;
    s0 = n_starts;
    nd = 0;
    t2 = 0;
    rereq = 1'b0;
    errs = '0;
    run_req(3'b111, c0);
    for (int n = 0; n < 300 && nd < 4; n++) begin
      if (done != 3'b000) begin
        ord[nd]  = oh2idx(done);
        res[nd]  = result;
        errs[nd] = err;
        nd++;
        if (nd == 2) t2 = cyc;
      end
      if (nd == 2 && !rereq && cyc - t2 == 3) begin
        set_ops(0, 16'd50, 16'd5);
        req = 3'b001;
        rereq = 1'b1;
      end
      if (nd < 4) begin
        tick();
        req = '0;
      end
    end
    check("cont completions", nd, 4);
    check("cont order0", ord[0], 0);
    check("cont order1", ord[1], 1);
    check("cont order2", ord[2], 2);
    check("cont order3", ord[3], 0);
    check("cont res0", 32'(res[0]), 10);
    check("cont res1", 32'(res[1]), 30);
    check("cont res2", 32'(res[2]), 9);
    check("cont res3", 32'(res[3]), 10);
    check("cont errs", 32'(errs), 0);
    check("cont single_done", multi_done, 0);
    check("cont starts", n_starts - s0, 4);
    tick();

    // Busy at issue: start held off until busy falls
    set_ops(0, 16'd100, 16'd4);
    s0 = n_starts;
    force_busy = 1'b1;
    run_req(3'b001, c0);
    while (cyc - c0 < 7) tick();
    check("busy no_early_start", n_starts - s0, 0);
    force_busy = 1'b0;
    wait_done("busy", 200, at);
    check("busy starts", n_starts - s0, 1);
    check("busy start_cycle", last_start_cyc - c0, 8);
    check("busy result", 32'(result), 25);
    check("busy err", 32'(err), 0);
    check("busy latency", at - c0, 18);
    tick();

    // Watchdog: ready on the last allowed cycle wins; one cycle later times out
    set_ops(1, 16'd300, 16'd3);
    m_delay = 63;
    one_shot("to_edge", 1, 16'd100, 1'b0, 67);
    m_delay = 64;
    one_shot("to_late", 1, SAT_VALUE, 1'b1, 67);
    m_delay = 8;
    m_hang = 1'b1;
    one_shot("to_hang", 1, SAT_VALUE, 1'b1, 67);
    m_hang = 1'b0;
    set_ops(2, 16'd600, 16'd6);
    one_shot("to_after", 2, 16'd100, 1'b0, 12);

    // Reset while waiting for ready
    set_ops(0, 16'd1200, 16'd25);
    run_req(3'b001, c0);
    while (cyc - c0 < 6) tick();
    check("mrst gnt_before", 32'(gnt), 32'(3'b001));
    rst = 1'b0;
    force_busy = 1'b1;
    #1;
    check("mrst gnt", 32'(gnt), 0);
    check("mrst div_dividend", 32'(div_dividend), 0);
    check("mrst div_divisor", 32'(div_divisor), 0);
    check("mrst result", 32'(result), 0);
    check("mrst err_done_start", 32'({err, done, div_start}), 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    set_ops(1, 16'd90, 16'd9);
    s0 = n_starts;
    bad = 1'b0;
    run_req(3'b010, c0);
    while (cyc - c0 < 6) begin
      if (done != 3'b000 || n_starts != s0) bad = 1'b1;
      force_ready = (cyc - c0 == 3);
      if (cyc - c0 == 5) force_busy = 1'b0;
      tick();
    end
    force_ready = 1'b0;
    check("mrst held_in_issue", 32'(bad), 0);
    tick();
    force_ready = 1'b1;
    tick();
    force_ready = 1'b0;
    check("mrst stale_ready_ignored", 32'(done), 0);
    wait_done("mrst", 200, at);
    check("mrst starts", n_starts - s0, 1);
    check("mrst start_cycle", last_start_cyc - c0, 6);
    check("mrst done", 32'(done), 32'(3'b010));
    check("mrst result", 32'(result), 10);
    check("mrst err", 32'(err), 0);
    check("mrst latency", at - c0, 16);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
